// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   action_e           : per-edge action, listed in priority order
//   HANDLER_PC_DEFAULT : exception entry vector
//   EXC_W              : exception-code width shared with CP0
package pipe_pkg;

  localparam int          EXC_W              = 5;
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_REQ,
    ACT_FLUSH,
    ACT_STALL,
    ACT_ADV
  } action_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk : clock
//   clr : synchronous clear, dominates inc
//   inc : count one event this edge; holds at all-ones
//   cnt : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  import pipe_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (clr)      cnt_p1 <= '0;
    else if (inc) cnt_p1 <= sat_inc(cnt_p1);
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register for the five-stage MIPS core.
// Inputs in_* are latched into out_* according to one action per edge:
// reset > req (bubble, redirect to handler) > flush (bubble, keep PC/BD/exc)
// > stall (hold) > advance (load, Tnew saturating decrement).
//   clk, reset              : clock, synchronous active-high reset
//   stall, flush, req       : pipeline control
//   in_valid .. in_payload  : upstream slot contents
//   out_valid .. out_payload: registered slot contents
//   bubble_cnt, stall_cnt   : saturating event counters for the debug bus
module pipe_stage_reg #(
  parameter int          DATA_W       = 128,
  parameter int          TNEW_W       = 4,
  parameter int          EXC_W        = pipe_pkg::EXC_W,
  parameter int          STICKY_W     = 1,
  parameter logic [31:0] HANDLER_PC   = pipe_pkg::HANDLER_PC_DEFAULT,
  parameter bit          ZERO_INVALID = 1'b1,
  parameter int          CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                req,
  input  logic                in_valid,
  input  logic [31:0]         in_pc,
  input  logic                in_bd,
  input  logic [EXC_W-1:0]    in_exc,
  input  logic [STICKY_W-1:0] in_sticky,
  input  logic [TNEW_W-1:0]   in_tnew,
  input  logic [DATA_W-1:0]   in_payload,
  output logic                out_valid,
  output logic [31:0]         out_pc,
  output logic                out_bd,
  output logic [EXC_W-1:0]    out_exc,
  output logic [STICKY_W-1:0] out_sticky,
  output logic [TNEW_W-1:0]   out_tnew,
  output logic [DATA_W-1:0]   out_payload,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);
  import pipe_pkg::*;

  function automatic action_e sel_action(input logic rst, input logic rq,
                                         input logic fl, input logic st);
    if (rst)     return ACT_RESET;
    else if (rq) return ACT_REQ;
    else if (fl) return ACT_FLUSH;
    else if (st) return ACT_STALL;
    else         return ACT_ADV;
  endfunction

  // Tnew counts down toward zero and must never wrap.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  action_e act_p0;
  logic    keep_data_p0;

  always_comb begin
    act_p0       = sel_action(reset, req, flush, stall);
    keep_data_p0 = in_valid || !ZERO_INVALID;
  end

  logic                valid_p1;
  logic [31:0]         pc_p1;
  logic                bd_p1;
  logic [EXC_W-1:0]    exc_p1;
  logic [STICKY_W-1:0] sticky_p1;
  logic [TNEW_W-1:0]   tnew_p1;
  logic [DATA_W-1:0]   payload_p1;

  // p0 -> p1: stage register
  always_ff @(posedge clk) begin
    unique case (act_p0)
      ACT_RESET: begin
        valid_p1   <= 1'b0;
        pc_p1      <= '0;
        bd_p1      <= 1'b0;
        exc_p1     <= '0;
        sticky_p1  <= '0;
        tnew_p1    <= '0;
        payload_p1 <= '0;
      end
      ACT_REQ: begin
        valid_p1   <= 1'b0;
        pc_p1      <= HANDLER_PC;
        bd_p1      <= 1'b0;
        exc_p1     <= '0;
        sticky_p1  <= in_sticky;
        tnew_p1    <= '0;
        payload_p1 <= '0;
      end
      ACT_FLUSH: begin
        // Bubble keeps PC/BD/exc so a later exception on it reports correctly.
        valid_p1   <= 1'b0;
        pc_p1      <= in_pc;
        bd_p1      <= in_bd;
        exc_p1     <= in_exc;
        sticky_p1  <= in_sticky;
        tnew_p1    <= '0;
        payload_p1 <= '0;
      end
      ACT_STALL: begin
        valid_p1   <= valid_p1;
        pc_p1      <= pc_p1;
        bd_p1      <= bd_p1;
        exc_p1     <= exc_p1;
        sticky_p1  <= sticky_p1;
        tnew_p1    <= tnew_p1;
        payload_p1 <= payload_p1;
      end
      default: begin
        valid_p1   <= in_valid;
        pc_p1      <= in_pc;
        bd_p1      <= in_bd;
        exc_p1     <= in_exc;
        sticky_p1  <= in_sticky;
        tnew_p1    <= keep_data_p0 ? sat_dec(in_tnew) : '0;
        payload_p1 <= keep_data_p0 ? in_payload : '0;
      end
    endcase
  end

  assign out_valid   = valid_p1;
  assign out_pc      = pc_p1;
  assign out_bd      = bd_p1;
  assign out_exc     = exc_p1;
  assign out_sticky  = sticky_p1;
  assign out_tnew    = tnew_p1;
  assign out_payload = payload_p1;

  logic bubble_inc_p0;
  logic stall_inc_p0;

  always_comb begin
    bubble_inc_p0 = (act_p0 == ACT_REQ) || (act_p0 == ACT_FLUSH);
    stall_inc_p0  = (act_p0 == ACT_STALL);
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (reset),
    .inc (bubble_inc_p0),
    .cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc_p0),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed table, hand sequences, random run
// against a behavioural model. A second instance with 2-bit counters
// exercises counter saturation.
module tb_pipe_stage_reg;
  localparam int DATA_W = 128;
  localparam int TNEW_W = 4;
  localparam int EXC_W  = 5;
  localparam int STK_W  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, stall, flush, req, in_valid, in_bd;
  logic [31:0]       in_pc;
  logic [EXC_W-1:0]  in_exc;
  logic [STK_W-1:0]  in_sticky;
  logic [TNEW_W-1:0] in_tnew;
  logic [DATA_W-1:0] in_payload;

  logic              o_valid, o_bd, o2_valid, o2_bd;
  logic [31:0]       o_pc, o2_pc;
  logic [EXC_W-1:0]  o_exc, o2_exc;
  logic [STK_W-1:0]  o_sticky, o2_sticky;
  logic [TNEW_W-1:0] o_tnew, o2_tnew;
  logic [DATA_W-1:0] o_payload, o2_payload;
  logic [15:0]       o_bub, o_stl;
  logic [1:0]        o2_bub, o2_stl;

  pipe_stage_reg #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .in_sticky(in_sticky), .in_tnew(in_tnew), .in_payload(in_payload),
    .out_valid(o_valid), .out_pc(o_pc), .out_bd(o_bd), .out_exc(o_exc),
    .out_sticky(o_sticky), .out_tnew(o_tnew), .out_payload(o_payload),
    .bubble_cnt(o_bub), .stall_cnt(o_stl));

  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .in_sticky(in_sticky), .in_tnew(in_tnew), .in_payload(in_payload),
    .out_valid(o2_valid), .out_pc(o2_pc), .out_bd(o2_bd), .out_exc(o2_exc),
    .out_sticky(o2_sticky), .out_tnew(o2_tnew), .out_payload(o2_payload),
    .bubble_cnt(o2_bub), .stall_cnt(o2_stl));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: the stage contents as plain values, event counts as
  // unbounded integers clipped to the counter width when compared.
  logic              m_valid, m_bd;
  logic [31:0]       m_pc;
  logic [EXC_W-1:0]  m_exc;
  logic [STK_W-1:0]  m_sticky;
  int                m_tnew;
  logic [DATA_W-1:0] m_payload;
  int                m_bub, m_stl;

  function automatic int clip(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_valid = 0; m_pc = 0; m_bd = 0; m_exc = 0; m_sticky = 0;
      m_tnew = 0; m_payload = 0; m_bub = 0; m_stl = 0;
    end else if (req) begin
      m_valid = 0; m_pc = 32'h0000_4180; m_bd = 0; m_exc = 0;
      m_sticky = in_sticky; m_tnew = 0; m_payload = 0; m_bub++;
    end else if (flush) begin
      m_valid = 0; m_pc = in_pc; m_bd = in_bd; m_exc = in_exc;
      m_sticky = in_sticky; m_tnew = 0; m_payload = 0; m_bub++;
    end else if (stall) begin
      m_stl++;
    end else begin
      m_valid = in_valid; m_pc = in_pc; m_bd = in_bd; m_exc = in_exc;
      m_sticky = in_sticky;
      if (in_valid) begin
        m_payload = in_payload;
        m_tnew    = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
      end else begin
        m_payload = 0;
        m_tnew    = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},  o_valid,   m_valid);
    chk({tag, ".pc"},     o_pc,      m_pc);
    chk({tag, ".bd"},     o_bd,      m_bd);
    chk({tag, ".exc"},    o_exc,     m_exc);
    chk({tag, ".sticky"}, o_sticky,  m_sticky);
    chk({tag, ".tnew"},   o_tnew,    m_tnew[TNEW_W-1:0]);
    chk({tag, ".pay"},    o_payload, m_payload);
    chk({tag, ".bub"},    o_bub,     clip(m_bub, 16));
    chk({tag, ".stl"},    o_stl,     clip(m_stl, 16));
    chk({tag, ".pc2"},    o2_pc,     m_pc);
    chk({tag, ".bub2"},   o2_bub,    clip(m_bub, 2));
    chk({tag, ".stl2"},   o2_stl,    clip(m_stl, 2));
  endtask

  task automatic rand_inputs();
    in_valid   = 1'($urandom);
    in_pc      = $urandom & 32'hFFFF_FFFC;
    in_bd      = 1'($urandom);
    in_exc     = EXC_W'($urandom);
    in_sticky  = STK_W'($urandom);
    in_tnew    = TNEW_W'($urandom);
    in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  typedef struct {
    logic        stall, flush, req, valid, bd, sticky;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic [3:0]  tnew;
    logic [7:0]  pay;
    logic        e_valid, e_bd, e_sticky;
    logic [31:0] e_pc;
    logic [4:0]  e_exc;
    logic [3:0]  e_tnew;
    logic [7:0]  e_pay;
    int          e_bub, e_stl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // stall flush req valid bd sticky pc exc tnew pay | expected outputs
    tbl[0] = '{0,0,0,1,0,0,32'h3000,0,2,8'hA5, 1,0,0,32'h3000,0,1,8'hA5, 0,0};
    tbl[1] = '{0,0,0,1,0,0,32'h3004,0,0,8'h11, 1,0,0,32'h3004,0,0,8'h11, 0,0};
    tbl[2] = '{0,0,0,0,1,0,32'h3008,2,3,8'hFF, 0,1,0,32'h3008,2,0,8'h00, 0,0};
    tbl[3] = '{0,0,0,1,0,0,32'h300C,0,5,8'h22, 1,0,0,32'h300C,0,4,8'h22, 0,0};
    tbl[4] = '{1,0,0,1,1,1,32'h5000,7,9,8'h33, 1,0,0,32'h300C,0,4,8'h22, 0,1};
    tbl[5] = '{1,1,0,1,1,0,32'h3010,4,7,8'h44, 0,1,0,32'h3010,4,0,8'h00, 1,1};
    tbl[6] = '{0,1,1,1,1,1,32'h3020,3,6,8'h55, 0,0,1,32'h0000_4180,0,0,8'h00, 2,1};

    reset = 1; stall = 0; flush = 0; req = 0;
    rand_inputs();
    step(); step();
    chk("reset.pc", o_pc, 32'h0);
    chk("reset.valid", o_valid, 1'b0);
    chk("reset.cnt", {o_bub, o_stl}, 32'h0);
    check_model("reset");

    reset = 0;
    foreach (tbl[i]) begin
      stall = tbl[i].stall; flush = tbl[i].flush; req = tbl[i].req;
      in_valid = tbl[i].valid; in_bd = tbl[i].bd; in_sticky = tbl[i].sticky;
      in_pc = tbl[i].pc; in_exc = tbl[i].exc; in_tnew = tbl[i].tnew;
      in_payload = DATA_W'(tbl[i].pay);
      step();
      chk($sformatf("tbl%0d.valid", i),  o_valid,   tbl[i].e_valid);
      chk($sformatf("tbl%0d.pc", i),     o_pc,      tbl[i].e_pc);
      chk($sformatf("tbl%0d.bd", i),     o_bd,      tbl[i].e_bd);
      chk($sformatf("tbl%0d.exc", i),    o_exc,     tbl[i].e_exc);
      chk($sformatf("tbl%0d.sticky", i), o_sticky,  tbl[i].e_sticky);
      chk($sformatf("tbl%0d.tnew", i),   o_tnew,    tbl[i].e_tnew);
      chk($sformatf("tbl%0d.pay", i),    o_payload, DATA_W'(tbl[i].e_pay));
      chk($sformatf("tbl%0d.bub", i),    o_bub,     tbl[i].e_bub);
      chk($sformatf("tbl%0d.stl", i),    o_stl,     tbl[i].e_stl);
      check_model($sformatf("tbl%0d", i));
    end

    // Stall held while inputs change: contents frozen, Tnew not decremented.
    stall = 0; flush = 0; req = 0;
    in_valid = 1; in_pc = 32'h3100; in_tnew = 3; in_bd = 0; in_exc = 0; in_sticky = 0;
    in_payload = 128'h77;
    step();
    chk("pre_stall.tnew", o_tnew, 4'd2);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      step();
      chk($sformatf("stall%0d.pc", k),   o_pc,      32'h3100);
      chk($sformatf("stall%0d.tnew", k), o_tnew,    4'd2);
      chk($sformatf("stall%0d.pay", k),  o_payload, 128'h77);
    end
    chk("stall3.cnt", o_stl, 16'd4);
    chk("stall3.cnt2", o2_stl, 2'd3);
    for (int k = 0; k < 2; k++) begin
      rand_inputs();
      step();
    end
    chk("stall5.cnt", o_stl, 16'd6);
    chk("stall5.cnt2_sat", o2_stl, 2'd3);
    check_model("stall5");

    // Reset asserted mid-stall clears everything on that edge.
    reset = 1;
    step();
    chk("rst_mid.pc", o_pc, 32'h0);
    chk("rst_mid.stl", o_stl, 16'h0);
    chk("rst_mid.stl2", o2_stl, 2'h0);
    check_model("rst_mid");
    reset = 0; stall = 0;
    in_valid = 1; in_pc = 32'h3200; in_tnew = 1; in_payload = 128'hBEEF;
    step();
    chk("post_rst.pc", o_pc, 32'h3200);
    chk("post_rst.tnew", o_tnew, 4'd0);
    check_model("post_rst");

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      reset = ($urandom_range(0, 99) < 2);
      req   = ($urandom_range(0, 99) < 6);
      flush = ($urandom_range(0, 99) < 12);
      stall = ($urandom_range(0, 99) < 25);
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
